ysyx_23060251_axi_rd_arbiter: RTL and testbench

YSYX_23060251_AXI_RD_ARBITER -- requirements
Module: ysyx_23060251_axi_rd_arbiter

---
 rtl/ysyx_23060251_arb_pkg.sv | 26 ++
 rtl/ysyx_23060251_arb_pick.sv | 12 +
 rtl/ysyx_23060251_axi_rd_arbiter.sv | 144 ++++++++++++++
 tb/tb_ysyx_23060251_axi_rd_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060251_arb_pkg.sv
// Shared definitions for the two-master AXI read arbiter: bus widths, FSM
// state encoding, grant one-hot constants and AXI response codes.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 32
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 32
`endif

package ysyx_23060251_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_AR_FWD = 3'b010,
    ST_R_FWD  = 3'b100
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_23060251_arb_pick.sv
// Combinational winner selection between m0 (IFU) and m1 (LSU).
// On a tie the master not served last wins; last = 0 (m0) therefore favours m1.
module ysyx_23060251_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/ysyx_23060251_axi_rd_arbiter.sv
// Two-master AXI read arbiter with a single outstanding read on the slave.
// Define YSYX_23060251_ARB_RR_EN for round-robin; otherwise m1 has fixed priority.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 32
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 32
`endif

module ysyx_23060251_axi_rd_arbiter
  import ysyx_23060251_arb_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_i,

  input  logic                                  m0_ar_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] m0_ar_addr_i,
  output logic                                  m0_ar_ready_o,
  output logic                                  m0_r_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS-1:0] m0_r_data_o,
  output logic [1:0]                            m0_r_resp_o,
  input  logic                                  m0_r_ready_i,

  input  logic                                  m1_ar_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] m1_ar_addr_i,
  output logic                                  m1_ar_ready_o,
  output logic                                  m1_r_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS-1:0] m1_r_data_o,
  output logic [1:0]                            m1_r_resp_o,
  input  logic                                  m1_r_ready_i,

  output logic                                  s_ar_valid_o,
  output logic [`YSYX_23060251_AXI_ADDR_BUS-1:0] s_ar_addr_o,
  input  logic                                  s_ar_ready_i,
  input  logic                                  s_r_valid_i,
  input  logic [`YSYX_23060251_AXI_DATA_BUS-1:0] s_r_data_i,
  input  logic [1:0]                            s_r_resp_i,
  output logic                                  s_r_ready_o,

  output logic [1:0]                            grant_o
);

  arb_state_e state;
  logic [1:0] grant;
  logic [1:0] pick_gnt;
  logic       last;
  logic       ar_hs;
  logic       r_hs;

  ysyx_23060251_arb_pick u_pick (
    .req  ({m1_ar_valid_i, m0_ar_valid_i}),
    .last (last),
    .gnt  (pick_gnt)
  );

`ifdef YSYX_23060251_ARB_RR_EN
  // Remembers who completed the most recent read; reset means "last = m0".
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     last <= 1'b0;
    else if (r_hs) last <= grant[1];
  end
`else
  assign last = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      grant <= GNT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|pick_gnt) begin
            grant <= pick_gnt;
            state <= ST_AR_FWD;
          end
        end
        ST_AR_FWD: begin
          if (ar_hs) state <= ST_R_FWD;
        end
        ST_R_FWD: begin
          if (r_hs) begin
            state <= ST_IDLE;
            grant <= GNT_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  // NOTE: every output gets a default first so the mux cannot infer a latch.
  always_comb begin
    s_ar_valid_o  = 1'b0;
    s_ar_addr_o   = '0;
    m0_ar_ready_o = 1'b0;
    m1_ar_ready_o = 1'b0;
    if (state == ST_AR_FWD) begin
      if (grant[0]) begin
        s_ar_valid_o  = m0_ar_valid_i;
        s_ar_addr_o   = m0_ar_addr_i;
        m0_ar_ready_o = s_ar_ready_i;
      end else if (grant[1]) begin
        s_ar_valid_o  = m1_ar_valid_i;
        s_ar_addr_o   = m1_ar_addr_i;
        m1_ar_ready_o = s_ar_ready_i;
      end
    end
  end

  // Slave read data is visible only to the owner, and only while in R_FWD.
  always_comb begin
    s_r_ready_o  = 1'b0;
    m0_r_valid_o = 1'b0;
    m0_r_data_o  = '0;
    m0_r_resp_o  = RESP_OKAY;
    m1_r_valid_o = 1'b0;
    m1_r_data_o  = '0;
    m1_r_resp_o  = RESP_OKAY;
    if (state == ST_R_FWD) begin
      if (grant[0]) begin
        s_r_ready_o  = m0_r_ready_i;
        m0_r_valid_o = s_r_valid_i;
        m0_r_data_o  = s_r_data_i;
        m0_r_resp_o  = s_r_resp_i;
      end else if (grant[1]) begin
        s_r_ready_o  = m1_r_ready_i;
        m1_r_valid_o = s_r_valid_i;
        m1_r_data_o  = s_r_data_i;
        m1_r_resp_o  = s_r_resp_i;
      end
    end
  end

  assign ar_hs   = s_ar_valid_o & s_ar_ready_i;
  assign r_hs    = s_r_valid_i & s_r_ready_o;
  assign grant_o = grant;

endmodule

// File: tb/tb_ysyx_23060251_axi_rd_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_ysyx_23060251_axi_rd_arbiter;

`ifdef YSYX_23060251_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [1:0]        ar_valid = '0;
  logic [1:0][31:0]  ar_addr = '0;
  logic [1:0]        r_ready = '0;
  logic              s_ar_ready_i = 1'b0;
  logic              s_r_valid_i = 1'b0;
  logic [31:0]       s_r_data_i = '0;
  logic [1:0]        s_r_resp_i = '0;

  wire  [1:0]        ar_ready;
  wire  [1:0]        r_valid;
  wire  [1:0][31:0]  r_data;
  wire  [1:0][1:0]   r_resp;
  wire               s_ar_valid_o;
  wire  [31:0]       s_ar_addr_o;
  wire               s_r_ready_o;
  wire  [1:0]        grant_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // stimulus knobs
  int ar_pct = 100, launch_pct = 100, spur_pct = 0;
  int rdy_pct [2] = '{100, 100};
  int lat_min = 0, lat_max = 0;
  bit fix_en = 1'b0;
  logic [31:0] fix_data = '0;
  logic [1:0]  fix_resp = '0;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  bit pending = 1'b0;
  int wait_cnt = 0;

  ysyx_23060251_axi_rd_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m0_ar_valid_i (ar_valid[0]),
    .m0_ar_addr_i  (ar_addr[0]),
    .m0_ar_ready_o (ar_ready[0]),
    .m0_r_valid_o  (r_valid[0]),
    .m0_r_data_o   (r_data[0]),
    .m0_r_resp_o   (r_resp[0]),
    .m0_r_ready_i  (r_ready[0]),
    .m1_ar_valid_i (ar_valid[1]),
    .m1_ar_addr_i  (ar_addr[1]),
    .m1_ar_ready_o (ar_ready[1]),
    .m1_r_valid_o  (r_valid[1]),
    .m1_r_data_o   (r_data[1]),
    .m1_r_resp_o   (r_resp[1]),
    .m1_r_ready_i  (r_ready[1]),
    .s_ar_valid_o  (s_ar_valid_o),
    .s_ar_addr_o   (s_ar_addr_o),
    .s_ar_ready_i  (s_ar_ready_i),
    .s_r_valid_i   (s_r_valid_i),
    .s_r_data_i    (s_r_data_i),
    .s_r_resp_i    (s_r_resp_i),
    .s_r_ready_o   (s_r_ready_o),
    .grant_o       (grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Behavioural reference: who owns the slave and whether its address went out.
  int  own = -1;
  bit  addr_sent = 1'b0;
  int  last_owner = 0;

  always @(negedge clk_i) begin : model
    logic [1:0]       e_grant, e_ar_ready, e_r_valid;
    logic [1:0][31:0] e_r_data;
    logic [1:0][1:0]  e_r_resp;
    logic             e_s_ar_valid, e_s_r_ready;
    logic [31:0]      e_s_ar_addr;
    e_grant = '0; e_ar_ready = '0; e_r_valid = '0; e_r_data = '0; e_r_resp = '0;
    e_s_ar_valid = 1'b0; e_s_r_ready = 1'b0; e_s_ar_addr = '0;
    if (rst_i) begin
      own = -1; addr_sent = 1'b0; last_owner = 0;
    end else if (own >= 0) begin
      e_grant = 2'(1 << own);
      if (!addr_sent) begin
        e_s_ar_valid    = ar_valid[own];
        e_s_ar_addr     = ar_addr[own];
        e_ar_ready[own] = s_ar_ready_i;
      end else begin
        e_s_r_ready    = r_ready[own];
        e_r_valid[own] = s_r_valid_i;
        e_r_data[own]  = s_r_data_i;
        e_r_resp[own]  = s_r_resp_i;
      end
    end
    check("m_grant", grant_o, e_grant);
    check("m_s_ar_valid", s_ar_valid_o, e_s_ar_valid);
    check("m_s_ar_addr", s_ar_addr_o, e_s_ar_addr);
    check("m_ar_ready", ar_ready, e_ar_ready);
    check("m_s_r_ready", s_r_ready_o, e_s_r_ready);
    check("m_r_valid", r_valid, e_r_valid);
    check("m_r_data", r_data, e_r_data);
    check("m_r_resp", r_resp, e_r_resp);
    if (!rst_i) begin
      if (own < 0) begin
        if (ar_valid == 2'b11)  own = RR ? (last_owner == 0 ? 1 : 0) : 1;
        else if (ar_valid[0])   own = 0;
        else if (ar_valid[1])   own = 1;
        addr_sent = 1'b0;
      end else if (!addr_sent) begin
        if (ar_valid[own] && s_ar_ready_i) addr_sent = 1'b1;
      end else if (s_r_valid_i && r_ready[own]) begin
        last_owner = own;
        own = -1;
        n_done++;
      end
    end
  end

  // One clock of stimulus: masters hold requests until accepted, slave answers
  // each accepted address after a random latency. Ends 2 time units after posedge.
  task automatic tick();
    logic [1:0] hs;
    logic sar_hs, sr_hs;
    @(negedge clk_i);
    hs     = ar_valid & ar_ready;
    sar_hs = s_ar_valid_o & s_ar_ready_i;
    sr_hs  = s_r_valid_i & s_r_ready_o;
    @(posedge clk_i);
    #1;
    if (hs[0]) begin void'(q0.pop_front()); ar_valid[0] = 1'b0; end
    if (hs[1]) begin void'(q1.pop_front()); ar_valid[1] = 1'b0; end
    if (!ar_valid[0] && q0.size() > 0 && pct(launch_pct)) begin
      ar_valid[0] = 1'b1; ar_addr[0] = q0[0];
    end
    if (!ar_valid[1] && q1.size() > 0 && pct(launch_pct)) begin
      ar_valid[1] = 1'b1; ar_addr[1] = q1[0];
    end
    r_ready[0]   = pct(rdy_pct[0]);
    r_ready[1]   = pct(rdy_pct[1]);
    s_ar_ready_i = pct(ar_pct);
    if (sr_hs) pending = 1'b0;
    if (sar_hs) begin
      pending = 1'b1;
      s_r_valid_i = 1'b0;
      wait_cnt = $urandom_range(lat_min, lat_max);
    end
    if (rst_i) pending = 1'b0;
    if (pending) begin
      if (!s_r_valid_i) begin
        if (wait_cnt == 0) begin
          s_r_valid_i = 1'b1;
          s_r_data_i  = fix_en ? fix_data : $urandom;
          s_r_resp_i  = fix_en ? fix_resp : 2'($urandom);
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      s_r_valid_i = pct(spur_pct);
      s_r_data_i  = $urandom;
      s_r_resp_i  = 2'($urandom);
    end
    #1;
  endtask

  task automatic start_test();
    rst_i = 1'b1;
    q0.delete(); q1.delete();
    ar_valid = '0;
    ar_pct = 100; launch_pct = 100; spur_pct = 0;
    rdy_pct[0] = 100; rdy_pct[1] = 100;
    lat_min = 0; lat_max = 0; fix_en = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit hs_seen;
    logic [1:0] prev_g;
    logic [1:0] seq [$];
    logic [1:0] exp_seq [4];

    // Reset: everything reads 0 even with requests and slave activity present.
    ar_valid = 2'b11; ar_addr[0] = 32'h1234; ar_addr[1] = 32'h5678;
    r_ready = 2'b11; s_ar_ready_i = 1'b1; s_r_valid_i = 1'b1; s_r_data_i = 32'hFFFF_FFFF;
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_ar_valid", s_ar_valid_o, 1'b0);
    check("rst_s_r_ready", s_r_ready_o, 1'b0);
    check("rst_ar_ready", ar_ready, 2'b00);
    check("rst_r_valid", r_valid, 2'b00);
    check("rst_r_data", r_data, 64'h0);

    // m0 alone reads 0x8000_0000, slave answers 0x13 two cycles after the address.
    start_test();
    spur_pct = 100; lat_min = 2; lat_max = 2;
    fix_en = 1'b1; fix_data = 32'h13; fix_resp = 2'b00;
    q0.push_back(32'h8000_0000);
    tick();
    check("a_idle_grant", grant_o, 2'b00);
    check("a_idle_ar_ready", ar_ready, 2'b00);
    check("a_idle_spurious_r_ready", s_r_ready_o, 1'b0);
    check("a_idle_spurious_r_valid", r_valid, 2'b00);
    tick();
    check("a_ar_grant", grant_o, 2'b01);
    check("a_ar_valid", s_ar_valid_o, 1'b1);
    check("a_ar_addr", s_ar_addr_o, 32'h8000_0000);
    n = 0;
    do begin
      tick(); n++;
      check("a_r_grant", grant_o, 2'b01);
      check("a_m1_r_valid", r_valid[1], 1'b0);
    end while (!r_valid[0] && n < 10);
    check("a_r_wait_cycles", n, 3);
    check("a_m0_r_valid", r_valid[0], 1'b1);
    check("a_m0_r_data", r_data[0], 32'h13);
    check("a_s_r_ready", s_r_ready_o, 1'b1);
    tick();
    check("a_back_idle", grant_o, 2'b00);

    // Simultaneous requests from both masters, repeated ties.
    start_test();
    q0.push_back(32'h100); q0.push_back(32'h104);
    q1.push_back(32'h200); q1.push_back(32'h204);
    prev_g = 2'b00;
    seq.delete();
    for (int k = 0; k < 60 && seq.size() < 4; k++) begin
      tick();
      if (grant_o != 2'b00 && prev_g == 2'b00) seq.push_back(grant_o);
      prev_g = grant_o;
    end
    if (RR) exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
    else    exp_seq = '{2'b10, 2'b10, 2'b01, 2'b01};
    check("t_grant_count", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t_grant_%0d", i), (i < seq.size()) ? seq[i] : 2'bxx, exp_seq[i]);

    // m1 requests while m0 is in its data phase.
    start_test();
    lat_min = 3; lat_max = 3;
    q0.push_back(32'h1000);
    n = 0;
    while (grant_o != 2'b01 && n < 10) begin tick(); n++; end
    check("d_grant_m0", grant_o, 2'b01);
    tick();
    q1.push_back(32'h2000);
    hs_seen = 1'b0;
    for (int k = 0; k < 12 && !hs_seen; k++) begin
      tick();
      check("d_m1_blocked", ar_ready[1], 1'b0);
      hs_seen = r_valid[0] & r_ready[0];
    end
    check("d_m0_r_hs", hs_seen, 1'b1);
    tick();
    check("d_idle", grant_o, 2'b00);
    tick();
    check("d_m1_grant", grant_o, 2'b10);

    // Slave holds valid while m0 is not ready for 5 cycles.
    start_test();
    rdy_pct[0] = 0;
    q0.push_back(32'h3000);
    n = 0;
    while (!r_valid[0] && n < 10) begin tick(); n++; end
    check("e_r_valid", r_valid[0], 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("e_r_ready_low", s_r_ready_o, 1'b0);
      check("e_grant_held", grant_o, 2'b01);
      tick();
    end
    rdy_pct[0] = 100;
    tick();
    check("e_r_ready_high", s_r_ready_o, 1'b1);
    tick();
    check("e_idle", grant_o, 2'b00);

    // SLVERR delivered to m1 unchanged.
    start_test();
    lat_min = 1; lat_max = 1;
    fix_en = 1'b1; fix_data = 32'hDEAD_BEEF; fix_resp = 2'b10;
    q1.push_back(32'h4000);
    n = 0;
    while (!r_valid[1] && n < 10) begin tick(); n++; end
    check("f_r_valid", r_valid[1], 1'b1);
    check("f_m1_resp", r_resp[1], 2'b10);
    check("f_m1_data", r_data[1], 32'hDEAD_BEEF);
    check("f_m0_resp", r_resp[0], 2'b00);
    tick();
    check("f_idle", grant_o, 2'b00);

    // Reset mid-cycle while the address is being forwarded, then a fresh read.
    start_test();
    ar_pct = 0;
    q0.push_back(32'h5000);
    n = 0;
    while (grant_o != 2'b01 && n < 10) begin tick(); n++; end
    check("g_ar_valid", s_ar_valid_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    check("g_rst_grant", grant_o, 2'b00);
    check("g_rst_ar_valid", s_ar_valid_o, 1'b0);
    check("g_rst_ar_addr", s_ar_addr_o, 32'h0);
    tick(); tick();
    rst_i = 1'b0;
    ar_pct = 100; lat_min = 1; lat_max = 1;
    fix_en = 1'b1; fix_data = 32'h55; fix_resp = 2'b00;
    hs_seen = 1'b0;
    for (int k = 0; k < 15 && !hs_seen; k++) begin
      tick();
      hs_seen = r_valid[0] & r_ready[0];
    end
    check("g_fresh_done", hs_seen, 1'b1);
    check("g_fresh_data", r_data[0], 32'h55);

    // Randomized traffic, checked cycle by cycle against the model.
    start_test();
    n = n_done;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        ar_pct     = $urandom_range(20, 100);
        rdy_pct[0] = $urandom_range(30, 100);
        rdy_pct[1] = $urandom_range(30, 100);
        lat_min    = 0;
        lat_max    = $urandom_range(0, 4);
        spur_pct   = $urandom_range(0, 50);
        launch_pct = $urandom_range(30, 100);
      end
      if (q0.size() < 3 && pct(25)) q0.push_back($urandom);
      if (q1.size() < 3 && pct(25)) q1.push_back($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #1 rst_i = 1'b1;
        #1 check("r_rst_grant", grant_o, 2'b00);
        tick();
        rst_i = 1'b0;
      end
      tick();
    end
    check("r_progress", (n_done - n) > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
